// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared channel layout and injection scheduler state encoding
package noc_pkg;

   // Scheduler ownership state: IDLE arbitrates heads, LOCKED streams one packet
   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   // Channel word is {valid, head, tail, payload}; payload sits at the bottom
   localparam int CH_PAYLOAD_LSB = 0;

   function automatic int ch_tail_bit(input int payload_w);
      return payload_w;
   endfunction

   function automatic int ch_head_bit(input int payload_w);
      return payload_w + 1;
   endfunction

   function automatic int ch_valid_bit(input int payload_w);
      return payload_w + 2;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker starting at a pointer
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          any
);

   // First requesting index at or after ptr, wrapping from N-1 back to 0
   always_comb begin : pick
      int   k;
      logic found;
      grant = '0;
      idx   = '0;
      found = 1'b0;
      k     = 0;
      for (int off = 0; off < N; off++) begin
         k = (int'(ptr) + off) % N;
         if (!found && req[IW'(k)]) begin
            found           = 1'b1;
            grant[IW'(k)]   = 1'b1;
            idx             = IW'(k);
         end
      end
      any = |req;
   end

endmodule

// File: rtl/router_inject_sched.sv
// rtl/router_inject_sched.sv - wormhole round-robin scheduler for the local injection channel
module router_inject_sched
   import noc_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int PAYLOAD_W = 31,
   parameter int CHANNEL_W = PAYLOAD_W + 3,
   parameter int BUF_DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [N_REQ-1:0]             req_valid,
   input  logic [N_REQ-1:0]             req_head,
   input  logic [N_REQ-1:0]             req_tail,
   input  logic [N_REQ*PAYLOAD_W-1:0]   req_data,
   output logic [N_REQ-1:0]             req_ready,
   input  logic                         credit_in,
   output logic [CHANNEL_W-1:0]         channel_out,
   output logic [$clog2(N_REQ)-1:0]     grant_id,
   output logic                         busy,
   output logic                         error
);

   localparam int IDX_W    = $clog2(N_REQ);
   localparam int CRED_W   = $clog2(BUF_DEPTH + 1);
   localparam int CH_VALID = ch_valid_bit(PAYLOAD_W);
   localparam int CH_HEAD  = ch_head_bit(PAYLOAD_W);
   localparam int CH_TAIL  = ch_tail_bit(PAYLOAD_W);
   localparam logic [CRED_W-1:0] CRED_FULL = CRED_W'(BUF_DEPTH);

   state_t               state;
   logic [CRED_W-1:0]    credits;
   logic [IDX_W-1:0]     rr_ptr;

   logic [N_REQ-1:0]     arb_grant;
   logic [IDX_W-1:0]     arb_idx;
   logic                 arb_any;

   logic [N_REQ-1:0]     ready_int;
   logic                 accept;
   logic [IDX_W-1:0]     sel;
   logic                 acc_head;
   logic                 acc_tail;
   logic [PAYLOAD_W-1:0] acc_data;
   logic                 has_credit;
   logic                 err_now;

   logic [PAYLOAD_W-1:0] data_arr [N_REQ];

   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
      if (int'(i) == N_REQ - 1) return '0;
      return i + IDX_W'(1);
   endfunction

   for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign data_arr[g] = req_data[g*PAYLOAD_W +: PAYLOAD_W];
   end

   // Only packet heads compete for the channel while it is free
   rr_arbiter #(.N(N_REQ), .IW(IDX_W)) u_arb (
      .req   (req_valid & req_head),
      .ptr   (rr_ptr),
      .grant (arb_grant),
      .idx   (arb_idx),
      .any   (arb_any)
   );

   assign has_credit = (credits != '0);

   // Ready: arbitration winner when free, owner's body/tail flit when locked; nothing without credit
   always_comb begin
      ready_int = '0;
      if (!reset && has_credit) begin
         if (state == IDLE) begin
            if (arb_any) ready_int = arb_grant;
         end else if (req_valid[grant_id] && !req_head[grant_id]) begin
            ready_int[grant_id] = 1'b1;
         end
      end
   end

   assign req_ready = ready_int;
   assign accept    = |(ready_int & req_valid);
   assign sel       = (state == IDLE) ? arb_idx : grant_id;
   assign acc_head  = req_head[sel];
   assign acc_tail  = req_tail[sel];
   assign acc_data  = data_arr[sel];

   // Protocol violations: credit overflow, head inside a packet, body flit with no owner
   always_comb begin
      err_now = 1'b0;
      if (credit_in && (credits == CRED_FULL) && !accept) err_now = 1'b1;
      if ((state == LOCKED) && req_valid[grant_id] && req_head[grant_id]) err_now = 1'b1;
      if ((state == IDLE) && |(req_valid & ~req_head)) err_now = 1'b1;
   end

   // Ownership FSM: grab on head, release on tail, advance rr pointer past the finished owner
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         busy     <= 1'b0;
         grant_id <= '0;
         rr_ptr   <= '0;
      end else if (accept) begin
         if (state == IDLE) begin
            grant_id <= sel;
            if (acc_tail) begin
               rr_ptr <= next_idx(sel);
            end else begin
               state <= LOCKED;
               busy  <= 1'b1;
            end
         end else if (acc_tail) begin
            state  <= IDLE;
            busy   <= 1'b0;
            rr_ptr <= next_idx(grant_id);
         end
      end
   end

   // Downstream credit counter; a returned credit with no slot to restore is dropped
   always_ff @(posedge clk) begin
      if (reset) begin
         credits <= CRED_FULL;
      end else if (accept && !credit_in) begin
         credits <= credits - CRED_W'(1);
      end else if (!accept && credit_in && (credits != CRED_FULL)) begin
         credits <= credits + CRED_W'(1);
      end
   end

   // Output register: accepted flit one cycle later, all-zero otherwise
   always_ff @(posedge clk) begin
      if (reset || !accept) begin
         channel_out <= '0;
      end else begin
         channel_out                                     <= '0;
         channel_out[CH_VALID]                           <= 1'b1;
         channel_out[CH_HEAD]                            <= acc_head;
         channel_out[CH_TAIL]                            <= acc_tail;
         channel_out[CH_PAYLOAD_LSB +: PAYLOAD_W]        <= acc_data;
      end
   end

   // Sticky error flag, cleared only by reset
   always_ff @(posedge clk) begin
      if (reset) begin
         error <= 1'b0;
      end else if (err_now) begin
         error <= 1'b1;
      end
   end

endmodule
